mem_sram_controller: RTL

- Sequences every MEM-stage data access onto an external 16-bit asynchronous SRAM. Each 32-bit load or store is split into two half-word SRAM cycles with programmable wait states.
- Sits between the memory stage (which supplies the ALU address, the Rm store data and the read/write enables) and the SRAM pins.
- Drives a ready signal. Pipeline control uses it to freeze IF through MEM until the access completes.

---
 rtl/mem_sram_controller_if.sv | 28 ++
 rtl/mem_sram_controller.sv | 113 +++++++++++
 2 files changed

// File: rtl/mem_sram_controller_if.sv
// rtl/mem_sram_controller_if.sv - MEM-stage request and async SRAM pin bundle
interface mem_sram_controller_if #(
    parameter int DATA_W  = 32,
    parameter int SRAM_DW = 16,
    parameter int SRAM_AW = 18
);
    logic               mem_r_en;
    logic               mem_w_en;
    logic [DATA_W-1:0]  addr;
    logic [DATA_W-1:0]  wdata;
    logic [DATA_W-1:0]  rdata;
    logic               ready;
    logic [SRAM_AW-1:0] sram_addr;
    logic [SRAM_DW-1:0] sram_dq_out;
    logic               sram_dq_oe;
    logic [SRAM_DW-1:0] sram_dq_in;
    logic               sram_we_n;

    modport master (
        output mem_r_en, mem_w_en, addr, wdata, sram_dq_in,
        input  rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    modport slave (
        input  mem_r_en, mem_w_en, addr, wdata, sram_dq_in,
        output rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );
endinterface

// File: rtl/mem_sram_controller.sv
// rtl/mem_sram_controller.sv - splits 32-bit loads/stores into two 16-bit SRAM cycles
module mem_sram_controller #(
    parameter int DATA_W      = 32,
    parameter int SRAM_DW     = 16,
    parameter int SRAM_AW     = 18,
    parameter int WAIT_CYCLES = 1,
    parameter int BASE_ADDR   = 1024
) (
    input logic                 clk,
    input logic                 rst,
    mem_sram_controller_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    localparam logic [3:0]        WAIT_LAST = 4'(WAIT_CYCLES);
    localparam logic [DATA_W-1:0] BASE      = DATA_W'(BASE_ADDR);

    state_t             state, state_next;
    logic [3:0]         wait_cnt;
    logic               op_wr;
    logic [SRAM_AW-2:0] lat_word;
    logic [DATA_W-1:0]  lat_wdata;
    logic [DATA_W-1:0]  rdata_q;
    logic [DATA_W-1:0]  offset;
    logic               req;
    logic               phase_end;
    logic               unused_offset_bits;

    assign req       = bus.mem_w_en | bus.mem_r_en;
    assign offset    = bus.addr - BASE;
    assign phase_end = (wait_cnt == WAIT_LAST);
    assign bus.rdata = rdata_q;

    // Byte offset bits and the out-of-range high bits are dropped by the map.
    assign unused_offset_bits = ^{offset[DATA_W-1:SRAM_AW+1], offset[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt  <= '0;
            op_wr     <= 1'b0;
            lat_word  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            if (state == IDLE && req) begin
                op_wr     <= bus.mem_w_en;
                lat_word  <= offset[SRAM_AW:2];
                lat_wdata <= bus.wdata;
            end
            if ((state == LO || state == HI) && !phase_end) begin
                wait_cnt <= wait_cnt + 4'd1;
            end else begin
                wait_cnt <= '0;
            end
            // Sample the bus at the end of each phase, after the full access time.
            if (state == LO && phase_end && !op_wr) begin
                rdata_q[SRAM_DW-1:0] <= bus.sram_dq_in;
            end
            if (state == HI && phase_end && !op_wr) begin
                rdata_q[DATA_W-1:SRAM_DW] <= bus.sram_dq_in;
            end
        end
    end

    always_comb begin
        state_next      = state;
        bus.ready       = 1'b0;
        bus.sram_addr   = '0;
        bus.sram_dq_out = '0;
        bus.sram_dq_oe  = 1'b0;
        bus.sram_we_n   = 1'b1;
        case (state)
            IDLE: begin
                if (req) begin
                    state_next = LO;
                end else begin
                    bus.ready = 1'b1;
                end
            end
            LO: begin
                bus.sram_addr   = {lat_word, 1'b0};
                bus.sram_dq_oe  = op_wr;
                bus.sram_we_n   = !op_wr;
                bus.sram_dq_out = op_wr ? lat_wdata[SRAM_DW-1:0] : '0;
                if (phase_end) begin
                    state_next = HI;
                end
            end
            HI: begin
                bus.sram_addr   = {lat_word, 1'b1};
                bus.sram_dq_oe  = op_wr;
                bus.sram_we_n   = !op_wr;
                bus.sram_dq_out = op_wr ? lat_wdata[DATA_W-1:SRAM_DW] : '0;
                if (phase_end) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.ready  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule
